pipe_control_unit: RTL and testbench
====================================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter OPCODEWIDTH, default 4, opcode width (>=4).
REQ-002 SHALL have parameter REGWIDTH, default 4, register-address width.
REQ-003 SHALL have parameter OUT_HOLD, default 2, cycles an OUT instruction occupies M (>=1).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port opcodeD  in  OPCODEWIDTH  decode-stage opcode.
REQ-007 SHALL have port validD  in  1  decode-stage instruction valid.
REQ-008 SHALL have ports rs1D, rs2D, rdD  in  REGWIDTH each  decode-stage sources and destination.
REQ-009 SHALL have port flushE  in  1  replace the next E contents with a bubble (branch taken).
REQ-010 SHALL have port stallFD  out  1  hold fetch/decode this cycle.
REQ-011 SHALL have ports obtainPCAsR1E, data2SelectorE  out  1 each, and aluControlE  out  3: E-stage controls.
REQ-012 SHALL have ports writeDataEnableM, outFlagM  out  1 each: M-stage controls.
REQ-013 SHALL have ports writeEnableWB, resultSelectorWB  out  1 each, and rdWB  out  REGWIDTH: WB-stage controls.
REQ-014 SHALL have port busy  out  1  high while the FSM is in HOLD.

Function
REQ-015 Decode SHALL be (we/mwe/d2/pc/rs/out; alu): 0000 LOAD we,rs;110 | 0001 STORE mwe;110 | 0010 IMM we,d2;111 | 0011 MOV we;110 | 0100 OUT out;110 | 0101/0110/0111/1000/1001 ALU we;000/001/100/010/101 | 1010 CMP;001 | 1011-1111 BRANCH pc,d2;000.
REQ-016 Unlisted opcodes (upper bits nonzero when OPCODEWIDTH>4) and validD=0 SHALL decode to NOP (all controls 0); no output is ever X.
REQ-017 The control bundle SHALL advance D->E->M->WB one stage per clock, giving 1/2/3-cycle latency from D to the E/M/WB outputs.
REQ-018 A load-use hazard SHALL be: E holds a valid LOAD with rdE!=0, and validD with rs1D==rdE or rs2D==rdE.
REQ-019 On a load-use hazard, stallFD SHALL be 1 that cycle and a bubble SHALL enter E; M and WB advance normally.
REQ-020 flushE SHALL force a bubble into E at the next edge, overriding both the decoded instruction and a hold.
REQ-021 The FSM SHALL have states RUN and HOLD.
REQ-022 In RUN with a valid OUT in M and OUT_HOLD>1, the FSM SHALL enter HOLD and load the counter with OUT_HOLD-1.
REQ-023 In HOLD, D/E/M SHALL hold (except REQ-020), a bubble SHALL enter WB, stallFD=1, and the counter decrements.
REQ-024 HOLD SHALL return to RUN when the counter reaches 1, so OUT occupies M exactly OUT_HOLD cycles.
REQ-025 outFlagM SHALL be 1 for every cycle a valid OUT is in M.
REQ-026 When a hazard and HOLD coincide, HOLD SHALL take priority; hazard detection re-evaluates after release.

Reset
REQ-027 Asserting reset SHALL immediately clear all stage bundles to NOP, valid bits to 0, rdE/rdM/rdWB to 0, FSM to RUN and counter to 0.
REQ-028 All outputs SHALL be 0 during reset; reset mid-HOLD SHALL abandon the OUT.

Structure
REQ-029 Package ctrl_pkg SHALL hold the opcode enum, ALU-control constants and the ctrl_bundle_t struct.
REQ-030 Combinational decode SHALL be a sub-module ctrl_decoder (opcode+valid -> ctrl_bundle_t); the rest of the logic stays in pipe_control_unit.

Verification
REQ-031 Reset then opcodes 0101,0010,0001 back-to-back -> aluControlE 000,111,110 on cycles 1-3; writeDataEnableM=1 on cycle 4.
REQ-032 LOAD rd=3, then ADD rs1=3 -> stallFD=1 for one cycle, E bubble, then ADD proceeds; rd=0 load -> no stall.
REQ-033 OUT with OUT_HOLD=3 -> outFlagM=1 for 3 cycles, busy=1 for 2 cycles, WB bubbles for 2 cycles.
REQ-034 Branch 1011 in D with flushE=1 -> all E outputs 0 next cycle; flushE during HOLD -> E cleared, M still held.
REQ-035 Reset asserted during HOLD -> busy=0 and all outputs 0 immediately, without waiting for a clock edge.
REQ-036 OPCODEWIDTH=6, opcode 6'b100101 -> NOP at every stage.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the pipeline control unit: opcode encoding, ALU control
// codes, the per-stage control bundle and the hold FSM states.
`timescale 1ns/1ps
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'b0000,
        OP_STORE = 4'b0001,
        OP_IMM   = 4'b0010,
        OP_MOV   = 4'b0011,
        OP_OUT   = 4'b0100,
        OP_ADD   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_AND   = 4'b0111,
        OP_OR    = 4'b1000,
        OP_XOR   = 4'b1001,
        OP_CMP   = 4'b1010,
        OP_BR0   = 4'b1011,
        OP_BR1   = 4'b1100,
        OP_BR2   = 4'b1101,
        OP_BR3   = 4'b1110,
        OP_BR4   = 4'b1111
    } opcode_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;
    localparam logic [2:0] ALU_IMM  = 3'b111;

    // valid marks a real instruction; a bubble is the all-zero bundle.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic       mwe;
        logic       d2;
        logic       pc;
        logic       rs;
        logic       out;
        logic [2:0] alu;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational decode of the D-stage opcode into a control bundle.
`timescale 1ns/1ps
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODEWIDTH = 4
) (
    input  logic [OPCODEWIDTH-1:0] opcode,
    input  logic                   valid,
    output ctrl_bundle_t           ctrl
);

    logic legal;

    // Any nonzero bit above the low nibble makes the opcode unlisted.
    assign legal = ((opcode >> 4) == '0);

    always_comb begin
        ctrl = CTRL_NOP;
        if (valid && legal) begin
            ctrl.valid = 1'b1;
            case (opcode[3:0])
                OP_LOAD:  begin ctrl.we = 1'b1; ctrl.rs = 1'b1; ctrl.alu = ALU_PASS; end
                OP_STORE: begin ctrl.mwe = 1'b1; ctrl.alu = ALU_PASS; end
                OP_IMM:   begin ctrl.we = 1'b1; ctrl.d2 = 1'b1; ctrl.alu = ALU_IMM; end
                OP_MOV:   begin ctrl.we = 1'b1; ctrl.alu = ALU_PASS; end
                OP_OUT:   begin ctrl.out = 1'b1; ctrl.alu = ALU_PASS; end
                OP_ADD:   begin ctrl.we = 1'b1; ctrl.alu = ALU_ADD; end
                OP_SUB:   begin ctrl.we = 1'b1; ctrl.alu = ALU_SUB; end
                OP_AND:   begin ctrl.we = 1'b1; ctrl.alu = ALU_AND; end
                OP_OR:    begin ctrl.we = 1'b1; ctrl.alu = ALU_OR; end
                OP_XOR:   begin ctrl.we = 1'b1; ctrl.alu = ALU_XOR; end
                OP_CMP:   begin ctrl.alu = ALU_SUB; end
                default:  begin ctrl.pc = 1'b1; ctrl.d2 = 1'b1; ctrl.alu = ALU_ADD; end
            endcase
        end
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Control bundle pipeline D->E->M->WB with load-use stall, E flush and an
// OUT hold FSM that keeps an OUT instruction in M for OUT_HOLD cycles.
`timescale 1ns/1ps
module pipe_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODEWIDTH = 4,
    parameter int REGWIDTH    = 4,
    parameter int OUT_HOLD    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OPCODEWIDTH-1:0] opcodeD,
    input  logic                   validD,
    input  logic [REGWIDTH-1:0]    rs1D,
    input  logic [REGWIDTH-1:0]    rs2D,
    input  logic [REGWIDTH-1:0]    rdD,
    input  logic                   flushE,
    output logic                   stallFD,
    output logic                   obtainPCAsR1E,
    output logic                   data2SelectorE,
    output logic [2:0]             aluControlE,
    output logic                   writeDataEnableM,
    output logic                   outFlagM,
    output logic                   writeEnableWB,
    output logic                   resultSelectorWB,
    output logic [REGWIDTH-1:0]    rdWB,
    output logic                   busy
);

    localparam int CW = $clog2(OUT_HOLD + 1);

    ctrl_bundle_t        dec;
    ctrl_bundle_t        ctl_e;
    logic [REGWIDTH-1:0] rd_e, rd_m, rd_wb;
    logic                we_m, mwe_m, rs_m, out_m;
    logic                we_wb, rs_wb;

    fsm_state_e          state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic                freeze;
    logic                hazard;

    ctrl_decoder #(
        .OPCODEWIDTH(OPCODEWIDTH)
    ) u_dec (
        .opcode(opcodeD),
        .valid (validD),
        .ctrl  (dec)
    );

    assign hazard = ctl_e.valid && ctl_e.rs && (rd_e != '0) && validD &&
                    ((rs1D == rd_e) || (rs2D == rd_e));

    // freeze covers the RUN cycle that enters HOLD as well, so the OUT
    // stays in M across that edge; the last HOLD cycle lets M advance.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        freeze     = 1'b0;
        case (state)
            ST_RUN: begin
                if (out_m && (OUT_HOLD > 1)) begin
                    state_next = ST_HOLD;
                    cnt_next   = CW'(OUT_HOLD - 1);
                    freeze     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt <= CW'(1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt - CW'(1);
                    freeze     = 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_e <= CTRL_NOP;
            rd_e  <= '0;
            we_m  <= 1'b0;
            mwe_m <= 1'b0;
            rs_m  <= 1'b0;
            out_m <= 1'b0;
            rd_m  <= '0;
            we_wb <= 1'b0;
            rs_wb <= 1'b0;
            rd_wb <= '0;
        end else if (freeze) begin
            we_wb <= 1'b0;
            rs_wb <= 1'b0;
            rd_wb <= '0;
            if (flushE) begin
                ctl_e <= CTRL_NOP;
                rd_e  <= '0;
            end
        end else begin
            we_wb <= we_m;
            rs_wb <= rs_m;
            rd_wb <= rd_m;
            we_m  <= ctl_e.we;
            mwe_m <= ctl_e.mwe;
            rs_m  <= ctl_e.rs;
            out_m <= ctl_e.out;
            rd_m  <= rd_e;
            if (flushE || hazard) begin
                ctl_e <= CTRL_NOP;
                rd_e  <= '0;
            end else begin
                ctl_e <= dec;
                rd_e  <= dec.valid ? rdD : '0;
            end
        end
    end

    assign stallFD          = freeze || hazard;
    assign busy             = (state == ST_HOLD);
    assign obtainPCAsR1E    = ctl_e.pc;
    assign data2SelectorE   = ctl_e.d2;
    assign aluControlE      = ctl_e.alu;
    assign writeDataEnableM = mwe_m;
    assign outFlagM         = out_m;
    assign writeEnableWB    = we_wb;
    assign resultSelectorWB = rs_wb;
    assign rdWB             = rd_wb;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed scenarios plus random traffic, all
// outputs compared every cycle against an instruction-level pipeline model.
`timescale 1ns/1ps
module tb_pipe_control_unit;

    localparam int OW = 6;
    localparam int RW = 4;
    localparam int OH = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [OW-1:0] opcodeD;
    logic          validD;
    logic [RW-1:0] rs1D, rs2D, rdD;
    logic          flushE;
    logic          stallFD, obtainPCAsR1E, data2SelectorE;
    logic [2:0]    aluControlE;
    logic          writeDataEnableM, outFlagM, writeEnableWB, resultSelectorWB;
    logic [RW-1:0] rdWB;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;
    bit exp_stall = 1'b0;

    pipe_control_unit #(
        .OPCODEWIDTH(OW),
        .REGWIDTH   (RW),
        .OUT_HOLD   (OH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .opcodeD         (opcodeD),
        .validD          (validD),
        .rs1D            (rs1D),
        .rs2D            (rs2D),
        .rdD             (rdD),
        .flushE          (flushE),
        .stallFD         (stallFD),
        .obtainPCAsR1E   (obtainPCAsR1E),
        .data2SelectorE  (data2SelectorE),
        .aluControlE     (aluControlE),
        .writeDataEnableM(writeDataEnableM),
        .outFlagM        (outFlagM),
        .writeEnableWB   (writeEnableWB),
        .resultSelectorWB(resultSelectorWB),
        .rdWB            (rdWB),
        .busy            (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {17'd0, stallFD, obtainPCAsR1E, data2SelectorE, aluControlE,
                writeDataEnableM, outFlagM, writeEnableWB, resultSelectorWB, rdWB, busy};
    endfunction

    // Controls per opcode: {we, mwe, d2, pc, rs, out, alu[2:0]}
    function automatic logic [8:0] tbl(input int op);
        case (op)
            0:  return 9'b100010110;
            1:  return 9'b010000110;
            2:  return 9'b101000111;
            3:  return 9'b100000110;
            4:  return 9'b000001110;
            5:  return 9'b100000000;
            6:  return 9'b100000001;
            7:  return 9'b100000100;
            8:  return 9'b100000010;
            9:  return 9'b100000101;
            10: return 9'b000000001;
            11, 12, 13, 14, 15: return 9'b001100000;
            default: return 9'b000000000;
        endcase
    endfunction

    // ---------------- instruction-level model ----------------
    // Slot 0=E, 1=M, 2=WB; m_age counts cycles the current M occupant has sat there.
    bit m_v[3] = '{0, 0, 0};
    int m_op[3];
    int m_rd[3];
    int m_age = 0;

    function automatic bit mdl_hazard();
        return m_v[0] && (m_op[0] == 0) && (m_rd[0] != 0) && validD &&
               ((int'(rs1D) == m_rd[0]) || (int'(rs2D) == m_rd[0]));
    endfunction

    function automatic bit mdl_freeze();
        return m_v[1] && (m_op[1] == 4) && (m_age < OH);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i] = 0; m_op[i] = 0; m_rd[i] = 0;
            end
            m_age = 0;
        end else begin
            bit hz, fz, in_v;
            hz = mdl_hazard();
            fz = mdl_freeze();
            in_v = validD && ((opcodeD >> 4) == 0);
            if (fz) begin
                m_age = m_age + 1;
                m_v[2] = 0; m_op[2] = 0; m_rd[2] = 0;
                if (flushE) begin m_v[0] = 0; m_op[0] = 0; m_rd[0] = 0; end
            end else begin
                m_v[2] = m_v[1]; m_op[2] = m_op[1]; m_rd[2] = m_rd[1];
                m_v[1] = m_v[0]; m_op[1] = m_op[0]; m_rd[1] = m_rd[0];
                m_age = 1;
                if (flushE || hz || !in_v) begin
                    m_v[0] = 0; m_op[0] = 0; m_rd[0] = 0;
                end else begin
                    m_v[0] = 1; m_op[0] = int'(opcodeD[3:0]); m_rd[0] = int'(rdD);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run_cmp) begin
            logic [8:0] ce, cm, cw;
            logic [31:0] wb_rd;
            ce = m_v[0] ? tbl(m_op[0]) : 9'd0;
            cm = m_v[1] ? tbl(m_op[1]) : 9'd0;
            cw = m_v[2] ? tbl(m_op[2]) : 9'd0;
            wb_rd = m_v[2] ? m_rd[2] : 0;
            exp_stall = mdl_freeze() || mdl_hazard();
            check("E_ctrl", {27'd0, obtainPCAsR1E, data2SelectorE, aluControlE},
                  {27'd0, ce[5], ce[6], ce[2:0]});
            check("M_ctrl", {30'd0, writeDataEnableM, outFlagM}, {30'd0, cm[7], cm[3]});
            check("WB_ctrl", {26'd0, writeEnableWB, resultSelectorWB, rdWB},
                  {26'd0, cw[8], cw[4], wb_rd[3:0]});
            check("stallFD", {31'd0, stallFD}, {31'd0, exp_stall});
            check("busy", {31'd0, busy}, {31'd0, m_v[1] && (m_op[1] == 4) && (m_age >= 2)});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int op, input bit v, input int r1, input int r2, input int rd);
        opcodeD = OW'(op);
        validD  = v;
        rs1D    = RW'(r1);
        rs2D    = RW'(r2);
        rdD     = RW'(rd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
        flushE = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k_out, k_imm, n_flag, n_busy;

        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 32'd0);
        reset = 1'b0;
        run_cmp = 1'b1;

        // Back-to-back ADD, IMM, STORE
        drive(5, 1, 0, 0, 1);  step();
        check("seq_alu_add", {29'd0, aluControlE}, 32'd0);
        drive(2, 1, 0, 0, 2);  step();
        check("seq_alu_imm", {29'd0, aluControlE}, 32'd7);
        drive(1, 1, 0, 0, 0);  step();
        check("seq_alu_store", {29'd0, aluControlE}, 32'd6);
        idle();                step();
        check("seq_store_m", {31'd0, writeDataEnableM}, 32'd1);
        drain();

        // Load-use hazard, then rd=0 load
        drive(0, 1, 0, 0, 3);  step();
        drive(6, 1, 3, 1, 4);  #1;
        check("lu_stall", {31'd0, stallFD}, 32'd1);
        step();
        check("lu_release", {31'd0, stallFD}, 32'd0);
        check("lu_e_bubble", {29'd0, aluControlE}, 32'd0);
        step();
        check("lu_sub_in_e", {29'd0, aluControlE}, 32'd1);
        check("lu_load_wb", {26'd0, writeEnableWB, resultSelectorWB, rdWB}, {26'd0, 2'b11, 4'd3});
        drain();
        drive(0, 1, 0, 0, 0);  step();
        drive(5, 1, 0, 0, 2);  #1;
        check("lu_rd0_nostall", {31'd0, stallFD}, 32'd0);
        drain();

        // OUT hold timing
        drive(4, 1, 0, 0, 0);  step();
        drive(2, 1, 0, 0, 5);  step();
        idle();
        k_out = -1; k_imm = -1; n_flag = 0; n_busy = 0;
        for (int k = 0; k < 12; k++) begin
            if (outFlagM) begin
                n_flag++;
                if (k_out < 0) k_out = k;
            end
            if (busy) n_busy++;
            if (writeEnableWB && rdWB == 4'd5 && k_imm < 0) k_imm = k;
            step();
        end
        check("out_flag_cycles", n_flag, 32'd3);
        check("out_busy_cycles", n_busy, 32'd2);
        check("out_wb_delay", k_imm - k_out, 32'd4);

        // Flush of a branch, and flush during HOLD
        drive(11, 1, 0, 0, 0);
        flushE = 1'b1;         step();
        check("flush_branch_e", {27'd0, obtainPCAsR1E, data2SelectorE, aluControlE}, 32'd0);
        drain();
        drive(4, 1, 0, 0, 0);  step();
        drive(2, 1, 0, 0, 5);  step();
        idle();                step();
        flushE = 1'b1;         step();
        check("flush_hold_e", {27'd0, obtainPCAsR1E, data2SelectorE, aluControlE}, 32'd0);
        check("flush_hold_m", {30'd0, outFlagM, busy}, 32'd3);
        drain();

        // Reset in the middle of HOLD
        drive(4, 1, 0, 0, 0);  step();
        idle();                step();
        step();
        check("hold_busy_pre", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_in_hold", out_vec(), 32'd0);
        #2 reset = 1'b0;
        step();
        drain();

        // Unlisted opcode with upper bits set
        drive(6'b100101, 1, 1, 2, 7);
        for (int k = 0; k < 3; k++) begin
            step();
            idle();
            #1 check("wide_op_nop", out_vec(), 32'd0);
        end
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step();
            if (i == 150) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
            if (!exp_stall) begin
                int r, op;
                r = $urandom_range(0, 19);
                if (r < 16) op = r;
                else op = ($urandom_range(1, 3) << 4) | $urandom_range(0, 15);
                drive(op, $urandom_range(0, 4) != 0, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            end
            flushE = ($urandom_range(0, 9) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
